// File: rtl/vlane_masked.sv
// vlane_masked: one vector lane with runtime vector length, per-element mask
// and a ready/valid start handshake. It walks the lane's owned elements
// (my_id + lanes*k) one per cycle. Writes go through a two-stage EX/WB
// pipeline, read-out is streamed combinationally, and sum-reduction is
// accumulated in place.
module vlane_masked #(
   parameter int els_p      = 32,
   parameter int vlen_p     = 8,
   parameter int vdw_p      = 32,
   parameter int lanes_p    = 4,
   parameter int op_width_p = 4,
   localparam int N   = vlen_p / lanes_p,
   localparam int ew  = (vlen_p > 1) ? $clog2(vlen_p) : 1,
   localparam int vlw = $clog2(vlen_p + 1),
   localparam int idw = (lanes_p > 1) ? $clog2(lanes_p) : 1
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic [idw-1:0]        my_id_i,
   input  logic                  v_i,
   output logic                  ready_o,
   input  logic [op_width_p-1:0] op_i,
   input  logic [vlw-1:0]        vl_i,
   input  logic [vlen_p-1:0]     mask_i,
   input  logic [vdw_p-1:0]      scalar_i,
   input  logic [vdw_p-1:0]      w_data_i,
   output logic [ew-1:0]         r_addr_o,
   input  logic [vdw_p-1:0]      r0_data_i,
   input  logic [vdw_p-1:0]      r1_data_i,
   output logic [ew-1:0]         w_addr_o,
   output logic [vdw_p-1:0]      w_data_o,
   output logic                  w_en_o,
   output logic [vdw_p-1:0]      r_data_o,
   output logic                  v_o,
   output logic [vdw_p-1:0]      red_o,
   output logic                  done_o
);

   localparam int kw = (N > 1) ? $clog2(N) : 1;

   localparam logic [op_width_p-1:0] OP_WRITE = op_width_p'(8);
   localparam logic [op_width_p-1:0] OP_READ  = op_width_p'(9);
   localparam logic [op_width_p-1:0] OP_RED   = op_width_p'(10);

   // Reject parameter sets the element walk cannot cover exactly.
   if ((vlen_p % lanes_p) != 0 || N < 1 || op_width_p < 4 || els_p < 1) begin : g_param_check
      $error("vlane_masked: illegal parameter combination");
   end

   typedef enum logic [1:0] {S_IDLE, S_LOOP, S_DRAIN, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [kw-1:0]         k_q;
   logic                  drain_q;
   logic [op_width_p-1:0] op_q;
   logic [vlw-1:0]        vl_q;
   logic [vlen_p-1:0]     mask_q;
   logic [vdw_p-1:0]      scalar_q;
   logic [vdw_p-1:0]      w_data_q;
   logic [vdw_p-1:0]      acc_q;
   logic [vdw_p-1:0]      red_q;

   logic                  ex_v_q, wb_v_q;
   logic [ew-1:0]         ex_addr_q, wb_addr_q;
   logic [vdw_p-1:0]      ex_data_q, wb_data_q;

   logic                  in_loop, in_drain, accept;
   logic [ew-1:0]         e_idx;
   logic [vlw-1:0]        vl_eff;
   logic                  elem_active;
   logic [vdw_p-1:0]      b_opnd, alu_res, wr_data;
   logic                  wr_req, is_read, is_red;

   // State register.
   always_ff @(posedge clk_i) begin
      if (reset_i) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic: IDLE -> LOOP (N cycles) -> DRAIN (2 cycles) -> DONE -> IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (v_i)                     state_d = S_LOOP;
         S_LOOP:  if (k_q == kw'(N - 1))       state_d = S_DRAIN;
         S_DRAIN: if (drain_q)                 state_d = S_DONE;
         S_DONE:                               state_d = S_IDLE;
         default:                              state_d = S_IDLE;
      endcase
   end

   // State-decoded outputs and qualifiers.
   always_comb begin
      ready_o  = (state_q == S_IDLE);
      done_o   = (state_q == S_DONE);
      in_loop  = (state_q == S_LOOP);
      in_drain = (state_q == S_DRAIN);
   end

   assign accept = v_i & ready_o;

   // Command latch, element counter, drain counter and reduction accumulator.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         k_q      <= '0;
         drain_q  <= 1'b0;
         op_q     <= '0;
         vl_q     <= '0;
         mask_q   <= '0;
         scalar_q <= '0;
         w_data_q <= '0;
         acc_q    <= '0;
      end else begin
         if (accept) begin
            op_q     <= op_i;
            vl_q     <= vl_i;
            mask_q   <= mask_i;
            scalar_q <= scalar_i;
            w_data_q <= w_data_i;
            k_q      <= '0;
            drain_q  <= 1'b0;
            acc_q    <= '0;
         end
         if (in_loop) begin
            k_q <= k_q + kw'(1);
            if (elem_active && is_red) acc_q <= acc_q + r0_data_i;
         end
         if (in_drain) drain_q <= ~drain_q;
      end
   end

   // Element address and activity: vl above vlen clamps to vlen.
   always_comb begin
      e_idx       = ew'(my_id_i) + ew'(lanes_p) * ew'(k_q);
      vl_eff      = (vl_q > vlw'(vlen_p)) ? vlw'(vlen_p) : vl_q;
      elem_active = (vlw'(e_idx) < vl_eff) && mask_q[e_idx];
   end

   // Opcode decode and element-wise ALU.
   always_comb begin
      is_read = (op_q == OP_READ);
      is_red  = (op_q == OP_RED);
      wr_req  = !op_q[3] || (op_q == OP_WRITE);
      b_opnd  = op_q[2] ? scalar_q : r1_data_i;
      case (op_q[1:0])
         2'b00:   alu_res = r0_data_i + b_opnd;
         2'b01:   alu_res = r0_data_i - b_opnd;
         2'b10:   alu_res = r0_data_i & b_opnd;
         default: alu_res = r0_data_i | b_opnd;
      endcase
      wr_data = op_q[3] ? w_data_q : alu_res;
   end

   // Pipeline valids and the reduction result; reset discards in-flight writes.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         ex_v_q <= 1'b0;
         wb_v_q <= 1'b0;
         red_q  <= '0;
      end else begin
         ex_v_q <= in_loop && elem_active && wr_req;
         wb_v_q <= ex_v_q;
         if (in_drain && drain_q && is_red) red_q <= acc_q;
      end
   end

   // Pipeline payload; only meaningful when the matching valid is set.
   always_ff @(posedge clk_i) begin
      ex_addr_q <= e_idx;
      ex_data_q <= wr_data;
      wb_addr_q <= ex_addr_q;
      wb_data_q <= ex_data_q;
   end

   assign r_addr_o = e_idx;
   assign w_en_o   = wb_v_q;
   assign w_addr_o = wb_addr_q;
   assign w_data_o = wb_data_q;
   assign r_data_o = r0_data_i;
   assign v_o      = in_loop && elem_active && is_read;
   assign red_o    = red_q;

endmodule
